hpi_responder: RTL and testbench

//  Target side of the 4-register OTG HPI port that the NIOS II drives through PIO exports
//  (address, data, r, w, cs, reset). Emulates the EZ-OTG HPI slave: DATA, MAILBOX, ADDRESS
//  and STATUS registers, a 16-bit word RAM with auto-incrementing pointer, and two mailboxes.

---
 rtl/hpi_responder_if.sv | 33 +++
 rtl/hpi_responder.sv | 240 ++++++++++++++++++++++++
 tb/tb_hpi_responder.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hpi_responder_if.sv
// ---------------------------------------------------------------------------
// hpi_responder_if
//   Pin bundle of the 4-register OTG HPI port as driven by the NIOS II PIO
//   exports.
//   master : initiator side (drives address, data_in, strobes, soft reset)
//   slave  : responder side (drives data_out)
//   Signals:
//     hpi_address  [1:0]  register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS
//     hpi_data_in  [15:0] write data from initiator
//     hpi_data_out [15:0] read data to initiator
//     hpi_r_n / hpi_w_n   read / write strobes, active low
//     hpi_cs_n            chip select, active low
//     hpi_reset_n         soft reset from initiator, active low
// ---------------------------------------------------------------------------
interface hpi_responder_if;
  logic [1:0]  hpi_address;
  logic [15:0] hpi_data_in;
  logic [15:0] hpi_data_out;
  logic        hpi_r_n;
  logic        hpi_w_n;
  logic        hpi_cs_n;
  logic        hpi_reset_n;

  modport master (
    output hpi_address, hpi_data_in, hpi_r_n, hpi_w_n, hpi_cs_n, hpi_reset_n,
    input  hpi_data_out
  );

  modport slave (
    input  hpi_address, hpi_data_in, hpi_r_n, hpi_w_n, hpi_cs_n, hpi_reset_n,
    output hpi_data_out
  );
endinterface

// File: rtl/hpi_responder.sv
// ---------------------------------------------------------------------------
// hpi_responder
//   On-chip stand-in for the EZ-OTG HPI slave. Provides DATA / MAILBOX /
//   ADDRESS / STATUS registers, a 2**AW x 16 word RAM behind an
//   auto-incrementing byte pointer, and two one-word mailboxes.
//   Ports:
//     clk_clk        system clock
//     reset_reset_n  asynchronous active-low reset
//     hpi            HPI pin bundle (slave modport)
//     mbx_in_data    last word the host wrote to MAILBOX
//     mbx_in_valid   host mailbox pending toward local logic
//     mbx_in_ack     one-cycle pulse, clears mbx_in_valid
//     mbx_out_data   local word to post to the host
//     mbx_out_wr     one-cycle pulse, loads mbx_out_data and sets mbx_out_full
//     mbx_out_full   message waiting for host (also the host interrupt)
// ---------------------------------------------------------------------------
module hpi_responder #(
  parameter int AW          = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  hpi_responder_if.slave        hpi,
  output logic [15:0]           mbx_in_data,
  output logic                  mbx_in_valid,
  input  logic                  mbx_in_ack,
  input  logic [15:0]           mbx_out_data,
  input  logic                  mbx_out_wr,
  output logic                  mbx_out_full
);

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_MBX  = 2'd1;
  localparam logic [1:0] REG_ADDR = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    ACCESS  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [1:0]  r_addr;
  logic        r_is_rd;
  logic [15:0] r_wdata;
  logic [15:0] r_ptr;
  logic        r_err;
  logic        r_err_hold;
  logic [15:0] r_data_out;
  logic [15:0] r_mbx_in_data;
  logic        r_mbx_in_valid;
  logic [15:0] r_mbx_out_data;
  logic        r_mbx_out_full;
  logic [15:0] r_ram_q;

  logic        w_both_low;
  logic        w_stable;
  logic        w_start;
  logic        w_commit;
  logic        w_ram_we;
  logic [AW-1:0] w_ram_idx;
  logic [15:0] w_status;
  logic [15:0] w_rd_mux;

  // Contention on the strobes: both asserted under chip select.
  assign w_both_low = !hpi.hpi_cs_n && !hpi.hpi_r_n && !hpi.hpi_w_n;

  // The bus still looks exactly like the access latched on entry to SETTLE.
  assign w_stable = !hpi.hpi_cs_n
                 && (hpi.hpi_r_n == !r_is_rd)
                 && (hpi.hpi_w_n == r_is_rd)
                 && (hpi.hpi_address == r_addr);

  assign w_status  = {r_err, 13'b0, r_mbx_in_valid, r_mbx_out_full};
  assign w_ram_idx = r_ptr[AW:1];
  assign w_ram_we  = w_commit && !r_is_rd && (r_addr == REG_DATA);

  always_comb begin
    w_rd_mux = 16'h0000;
    case (r_addr)
      REG_DATA: w_rd_mux = r_ram_q;
      REG_MBX:  w_rd_mux = r_mbx_out_data;
      REG_ADDR: w_rd_mux = r_ptr;
      REG_STAT: w_rd_mux = w_status;
      default:  w_rd_mux = 16'h0000;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      if (w_start)
        r_cnt <= 4'd0;
      else if (r_state == SETTLE)
        r_cnt <= r_cnt + 4'd1;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and control strobes
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      IDLE: begin
        // After contention, no new access until both strobes have gone high.
        if (!hpi.hpi_cs_n && (hpi.hpi_r_n ^ hpi.hpi_w_n) && !r_err_hold) begin
          w_state_next = SETTLE;
          w_start      = 1'b1;
        end
      end
      SETTLE: begin
        if (!w_stable)
          w_state_next = IDLE;
        else if (r_cnt == WAIT_LAST)
          w_state_next = ACCESS;
      end
      ACCESS: w_state_next = RELEASE;
      RELEASE: begin
        // Side effects land on the edge that leaves RELEASE, so a held
        // strobe can never produce a second access.
        if (hpi.hpi_cs_n || (r_is_rd ? hpi.hpi_r_n : hpi.hpi_w_n)) begin
          w_state_next = IDLE;
          w_commit     = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (!hpi.hpi_reset_n) begin
      w_state_next = IDLE;
      w_start      = 1'b0;
      w_commit     = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath: pointer, mailboxes, error flag, read data
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_addr         <= 2'd0;
      r_is_rd        <= 1'b0;
      r_wdata        <= 16'h0000;
      r_ptr          <= 16'h0000;
      r_err          <= 1'b0;
      r_err_hold     <= 1'b0;
      r_data_out     <= 16'h0000;
      r_mbx_in_data  <= 16'h0000;
      r_mbx_in_valid <= 1'b0;
      r_mbx_out_data <= 16'h0000;
      r_mbx_out_full <= 1'b0;
    end else if (!hpi.hpi_reset_n) begin
      r_addr         <= 2'd0;
      r_is_rd        <= 1'b0;
      r_wdata        <= 16'h0000;
      r_ptr          <= 16'h0000;
      r_err          <= 1'b0;
      r_err_hold     <= 1'b0;
      r_data_out     <= 16'h0000;
      r_mbx_in_data  <= 16'h0000;
      r_mbx_in_valid <= 1'b0;
      r_mbx_out_data <= 16'h0000;
      r_mbx_out_full <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr  <= hpi.hpi_address;
        r_is_rd <= !hpi.hpi_r_n;
      end

      if (w_both_low) begin
        r_err      <= 1'b1;
        r_err_hold <= 1'b1;
      end else if (hpi.hpi_r_n && hpi.hpi_w_n) begin
        r_err_hold <= 1'b0;
      end

      if (r_state == ACCESS) begin
        if (r_is_rd)
          r_data_out <= w_rd_mux;
        else
          r_wdata <= hpi.hpi_data_in;
      end else if (r_state == IDLE) begin
        r_data_out <= 16'h0000;
      end

      if (w_commit && (r_addr == REG_DATA))
        r_ptr <= r_ptr + 16'd2;
      else if (w_commit && !r_is_rd && (r_addr == REG_ADDR))
        r_ptr <= {r_wdata[15:1], 1'b0};

      // Host write beats a same-cycle local acknowledge.
      if (w_commit && !r_is_rd && (r_addr == REG_MBX)) begin
        r_mbx_in_data  <= r_wdata;
        r_mbx_in_valid <= 1'b1;
      end else if (mbx_in_ack) begin
        r_mbx_in_valid <= 1'b0;
      end

      // Local post beats a same-cycle host read.
      if (mbx_out_wr) begin
        r_mbx_out_data <= mbx_out_data;
        r_mbx_out_full <= 1'b1;
      end else if (w_commit && r_is_rd && (r_addr == REG_MBX)) begin
        r_mbx_out_full <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Word RAM, registered read, no reset so it maps onto block RAM.
  // The read port follows the pointer continuously; the pointer has been
  // stable for the whole SETTLE phase by the time ACCESS samples r_ram_q.
  // -------------------------------------------------------------------------
  logic [15:0] r_mem [0:(2**AW)-1];

  always_ff @(posedge clk_clk) begin
    if (w_ram_we)
      r_mem[w_ram_idx] <= r_wdata;
    r_ram_q <= r_mem[w_ram_idx];
  end

  assign hpi.hpi_data_out = r_data_out;
  assign mbx_in_data      = r_mbx_in_data;
  assign mbx_in_valid     = r_mbx_in_valid;
  assign mbx_out_full     = r_mbx_out_full;

endmodule

// File: tb/tb_hpi_responder.sv
// ---------------------------------------------------------------------------
// tb_hpi_responder
//   Self-checking bench for hpi_responder. Expected read values are pushed
//   onto a scoreboard queue when a read is issued and popped when the read
//   data is sampled from the bus.
// ---------------------------------------------------------------------------
module tb_hpi_responder;
  localparam int AW   = 10;
  localparam int WAIT = 2;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MBX  = 2'd1;
  localparam logic [1:0] A_ADDR = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  logic        clk;
  logic        rst_n;
  logic [15:0] mbx_in_data;
  logic        mbx_in_valid;
  logic        mbx_in_ack;
  logic [15:0] mbx_out_data;
  logic        mbx_out_wr;
  logic        mbx_out_full;

  int tot = 0;
  int bad = 0;
  logic [15:0] exp_q[$];

  hpi_responder_if hpi_bus();

  hpi_responder #(.AW(AW), .WAIT_CYCLES(WAIT)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .hpi           (hpi_bus.slave),
    .mbx_in_data   (mbx_in_data),
    .mbx_in_valid  (mbx_in_valid),
    .mbx_in_ack    (mbx_in_ack),
    .mbx_out_data  (mbx_out_data),
    .mbx_out_wr    (mbx_out_wr),
    .mbx_out_full  (mbx_out_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic hpi_write(input logic [1:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    hpi_bus.hpi_address = a;
    hpi_bus.hpi_data_in = d;
    hpi_bus.hpi_cs_n    = 1'b0;
    hpi_bus.hpi_w_n     = 1'b0;
    repeat (WAIT + 4) @(posedge clk);
    #1;
    hpi_bus.hpi_w_n  = 1'b1;
    hpi_bus.hpi_cs_n = 1'b1;
    repeat (2) @(posedge clk);
    $display("write addr=%0d data=0x%04h", a, d);
  endtask

  // Returns the data seen while the strobe is held, and the bus value once
  // the access has fully retired.
  task automatic hpi_read(input logic [1:0] a, output logic [15:0] d,
                          output logic [15:0] idle_d);
    @(posedge clk); #1;
    hpi_bus.hpi_address = a;
    hpi_bus.hpi_cs_n    = 1'b0;
    hpi_bus.hpi_r_n     = 1'b0;
    repeat (WAIT + 4) @(posedge clk);
    @(negedge clk);
    d = hpi_bus.hpi_data_out;
    @(posedge clk); #1;
    hpi_bus.hpi_r_n  = 1'b1;
    hpi_bus.hpi_cs_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle_d = hpi_bus.hpi_data_out;
    $display("read  addr=%0d data=0x%04h", a, d);
  endtask

  task automatic pulse_out_wr(input logic [15:0] d);
    @(posedge clk); #1;
    mbx_out_data = d;
    mbx_out_wr   = 1'b1;
    @(posedge clk); #1;
    mbx_out_wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [15:0] got, idle_d, e;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tot++; if (hpi_bus.hpi_data_out !== 16'h0000) begin bad++; $display("FAIL reset_data_out got=0x%04h exp=0x0000", hpi_bus.hpi_data_out); end
    tot++; if ({mbx_in_valid, mbx_out_full} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {mbx_in_valid, mbx_out_full}); end
    tot++; if (mbx_in_data !== 16'h0000) begin bad++; $display("FAIL reset_mbx_in_data got=0x%04h exp=0x0000", mbx_in_data); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.push_back(16'h0000);
    hpi_read(A_ADDR, got, idle_d);
    e = exp_q.pop_front();
    tot++; if (got !== e) begin bad++; $display("FAIL reset_ptr got=0x%04h exp=0x%04h", got, e); end
  endtask

  task automatic test_ram;
    logic [15:0] got, idle_d, e;
    hpi_write(A_ADDR, 16'h0010);
    hpi_write(A_DATA, 16'hAAAA);
    hpi_write(A_DATA, 16'h5555);
    hpi_write(A_ADDR, 16'h0010);
    exp_q.push_back(16'hAAAA);
    hpi_read(A_DATA, got, idle_d);
    e = exp_q.pop_front();
    tot++; if (got !== e) begin bad++; $display("FAIL ram_rd0 got=0x%04h exp=0x%04h", got, e); end
    tot++; if (idle_d !== 16'h0000) begin bad++; $display("FAIL ram_rd0_idle got=0x%04h exp=0x0000", idle_d); end
    exp_q.push_back(16'h5555);
    hpi_read(A_DATA, got, idle_d);
    e = exp_q.pop_front();
    tot++; if (got !== e) begin bad++; $display("FAIL ram_rd1 got=0x%04h exp=0x%04h", got, e); end
    exp_q.push_back(16'h0014);
    hpi_read(A_ADDR, got, idle_d);
    e = exp_q.pop_front();
    tot++; if (got !== e) begin bad++; $display("FAIL ram_ptr got=0x%04h exp=0x%04h", got, e); end
  endtask

  task automatic test_mbx_out;
    logic [15:0] got, idle_d, e;
    pulse_out_wr(16'h1234);
    tot++; if (mbx_out_full !== 1'b1) begin bad++; $display("FAIL mbx_out_full got=%b exp=1", mbx_out_full); end
    exp_q.push_back(16'h0001);
    hpi_read(A_STAT, got, idle_d);
    e = exp_q.pop_front();
    tot++; if (got !== e) begin bad++; $display("FAIL mbx_out_status got=0x%04h exp=0x%04h", got, e); end
    exp_q.push_back(16'h1234);
    hpi_read(A_MBX, got, idle_d);
    e = exp_q.pop_front();
    tot++; if (got !== e) begin bad++; $display("FAIL mbx_out_read got=0x%04h exp=0x%04h", got, e); end
    exp_q.push_back(16'h0000);
    hpi_read(A_STAT, got, idle_d);
    e = exp_q.pop_front();
    tot++; if (got !== e) begin bad++; $display("FAIL mbx_out_status_clr got=0x%04h exp=0x%04h", got, e); end
  endtask

  task automatic test_mbx_in;
    logic [15:0] got, idle_d, e;
    hpi_write(A_MBX, 16'hBEEF);
    @(negedge clk);
    tot++; if ({mbx_in_valid, mbx_in_data} !== {1'b1, 16'hBEEF}) begin bad++; $display("FAIL mbx_in_post got=%b/0x%04h exp=1/0xbeef", mbx_in_valid, mbx_in_data); end
    exp_q.push_back(16'h0002);
    hpi_read(A_STAT, got, idle_d);
    e = exp_q.pop_front();
    tot++; if (got !== e) begin bad++; $display("FAIL mbx_in_status got=0x%04h exp=0x%04h", got, e); end
    @(posedge clk); #1;
    mbx_in_ack = 1'b1;
    @(posedge clk); #1;
    mbx_in_ack = 1'b0;
    @(negedge clk);
    tot++; if (mbx_in_valid !== 1'b0) begin bad++; $display("FAIL mbx_in_ack got=%b exp=0", mbx_in_valid); end
  endtask

  task automatic test_short_and_err;
    logic [15:0] got, idle_d, e;
    int nz;
    nz = 0;
    @(posedge clk); #1;
    hpi_bus.hpi_address = A_DATA;
    hpi_bus.hpi_cs_n    = 1'b0;
    hpi_bus.hpi_r_n     = 1'b0;
    @(posedge clk); #1;
    hpi_bus.hpi_r_n  = 1'b1;
    hpi_bus.hpi_cs_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (hpi_bus.hpi_data_out !== 16'h0000) nz++;
    end
    tot++; if (nz !== 0) begin bad++; $display("FAIL short_data_out nonzero_cycles=%0d exp=0", nz); end
    exp_q.push_back(16'h0014);
    hpi_read(A_ADDR, got, idle_d);
    e = exp_q.pop_front();
    tot++; if (got !== e) begin bad++; $display("FAIL short_ptr got=0x%04h exp=0x%04h", got, e); end
    @(posedge clk); #1;
    hpi_bus.hpi_address = A_DATA;
    hpi_bus.hpi_cs_n    = 1'b0;
    hpi_bus.hpi_r_n     = 1'b0;
    hpi_bus.hpi_w_n     = 1'b0;
    repeat (WAIT + 4) @(posedge clk);
    #1;
    hpi_bus.hpi_r_n  = 1'b1;
    hpi_bus.hpi_w_n  = 1'b1;
    hpi_bus.hpi_cs_n = 1'b1;
    repeat (2) @(posedge clk);
    exp_q.push_back(16'h8000);
    hpi_read(A_STAT, got, idle_d);
    e = exp_q.pop_front();
    tot++; if (got !== e) begin bad++; $display("FAIL err_status got=0x%04h exp=0x%04h", got, e); end
    exp_q.push_back(16'h0014);
    hpi_read(A_ADDR, got, idle_d);
    e = exp_q.pop_front();
    tot++; if (got !== e) begin bad++; $display("FAIL err_no_access got=0x%04h exp=0x%04h", got, e); end
  endtask

  task automatic test_wrap_and_soft_reset;
    logic [15:0] got, idle_d, e;
    hpi_write(A_ADDR, 16'hFFFE);
    hpi_write(A_DATA, 16'h7777);
    exp_q.push_back(16'h0000);
    hpi_read(A_ADDR, got, idle_d);
    e = exp_q.pop_front();
    tot++; if (got !== e) begin bad++; $display("FAIL wrap_ptr got=0x%04h exp=0x%04h", got, e); end
    // 0x07FE and 0xFFFE share RAM index 0x3FF.
    hpi_write(A_ADDR, 16'h07FF);
    exp_q.push_back(16'h07FE);
    hpi_read(A_ADDR, got, idle_d);
    e = exp_q.pop_front();
    tot++; if (got !== e) begin bad++; $display("FAIL addr_bit0 got=0x%04h exp=0x%04h", got, e); end
    exp_q.push_back(16'h7777);
    hpi_read(A_DATA, got, idle_d);
    e = exp_q.pop_front();
    tot++; if (got !== e) begin bad++; $display("FAIL alias got=0x%04h exp=0x%04h", got, e); end
    pulse_out_wr(16'h4321);
    hpi_write(A_MBX, 16'h0F0F);
    exp_q.push_back(16'h8003);
    hpi_read(A_STAT, got, idle_d);
    e = exp_q.pop_front();
    tot++; if (got !== e) begin bad++; $display("FAIL pre_soft_status got=0x%04h exp=0x%04h", got, e); end
    @(posedge clk); #1;
    hpi_bus.hpi_reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tot++; if ({mbx_in_valid, mbx_out_full, mbx_in_data} !== 18'h0) begin bad++; $display("FAIL soft_mbx got=%b/%b/0x%04h exp=0/0/0x0000", mbx_in_valid, mbx_out_full, mbx_in_data); end
    @(posedge clk); #1;
    hpi_bus.hpi_reset_n = 1'b1;
    exp_q.push_back(16'h0000);
    hpi_read(A_ADDR, got, idle_d);
    e = exp_q.pop_front();
    tot++; if (got !== e) begin bad++; $display("FAIL soft_ptr got=0x%04h exp=0x%04h", got, e); end
    exp_q.push_back(16'h0000);
    hpi_read(A_STAT, got, idle_d);
    e = exp_q.pop_front();
    tot++; if (got !== e) begin bad++; $display("FAIL soft_status got=0x%04h exp=0x%04h", got, e); end
  endtask

  task automatic test_collision;
    logic [15:0] got, idle_d, e;
    pulse_out_wr(16'hAAAA);
    // Host MAILBOX read whose commit edge coincides with a local post.
    @(posedge clk); #1;
    hpi_bus.hpi_address = A_MBX;
    hpi_bus.hpi_cs_n    = 1'b0;
    hpi_bus.hpi_r_n     = 1'b0;
    repeat (WAIT + 4) @(posedge clk);
    @(negedge clk);
    tot++; if (hpi_bus.hpi_data_out !== 16'hAAAA) begin bad++; $display("FAIL coll_read got=0x%04h exp=0xaaaa", hpi_bus.hpi_data_out); end
    @(posedge clk); #1;
    hpi_bus.hpi_r_n  = 1'b1;
    hpi_bus.hpi_cs_n = 1'b1;
    mbx_out_data     = 16'hBBBB;
    mbx_out_wr       = 1'b1;
    @(posedge clk); #1;
    mbx_out_wr = 1'b0;
    @(negedge clk);
    tot++; if (mbx_out_full !== 1'b1) begin bad++; $display("FAIL coll_full got=%b exp=1", mbx_out_full); end
    exp_q.push_back(16'hBBBB);
    hpi_read(A_MBX, got, idle_d);
    e = exp_q.pop_front();
    tot++; if (got !== e) begin bad++; $display("FAIL coll_data got=0x%04h exp=0x%04h", got, e); end
    tot++; if (mbx_out_full !== 1'b0) begin bad++; $display("FAIL coll_full_clr got=%b exp=0", mbx_out_full); end
  endtask

  task automatic test_async_reset;
    logic [15:0] got, idle_d, e;
    hpi_write(A_ADDR, 16'h0040);
    hpi_write(A_DATA, 16'h1111);
    hpi_write(A_ADDR, 16'h0040);
    pulse_out_wr(16'h2468);
    hpi_write(A_MBX, 16'h5A5A);
    @(posedge clk); #1;
    hpi_bus.hpi_address = A_DATA;
    hpi_bus.hpi_data_in = 16'h2222;
    hpi_bus.hpi_cs_n    = 1'b0;
    hpi_bus.hpi_w_n     = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    tot++; if ({mbx_in_valid, mbx_out_full, mbx_in_data, hpi_bus.hpi_data_out} !== 34'h0) begin bad++; $display("FAIL areset_outputs got=%b/%b/0x%04h/0x%04h exp=all zero", mbx_in_valid, mbx_out_full, mbx_in_data, hpi_bus.hpi_data_out); end
    hpi_bus.hpi_w_n  = 1'b1;
    hpi_bus.hpi_cs_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.push_back(16'h0000);
    hpi_read(A_ADDR, got, idle_d);
    e = exp_q.pop_front();
    tot++; if (got !== e) begin bad++; $display("FAIL areset_ptr got=0x%04h exp=0x%04h", got, e); end
    hpi_write(A_ADDR, 16'h0040);
    exp_q.push_back(16'h1111);
    hpi_read(A_DATA, got, idle_d);
    e = exp_q.pop_front();
    tot++; if (got !== e) begin bad++; $display("FAIL areset_no_commit got=0x%04h exp=0x%04h", got, e); end
  endtask

  initial begin
    rst_n               = 1'b0;
    hpi_bus.hpi_address = 2'd0;
    hpi_bus.hpi_data_in = 16'h0000;
    hpi_bus.hpi_r_n     = 1'b1;
    hpi_bus.hpi_w_n     = 1'b1;
    hpi_bus.hpi_cs_n    = 1'b1;
    hpi_bus.hpi_reset_n = 1'b1;
    mbx_in_ack          = 1'b0;
    mbx_out_data        = 16'h0000;
    mbx_out_wr          = 1'b0;
    test_reset();
    test_ram();
    test_mbx_out();
    test_mbx_in();
    test_short_and_err();
    test_wrap_and_soft_reset();
    test_collision();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
